pong_game_ctrl: RTL and testbench

Frame-rate game controller for the single-paddle VGA Pong design (640x480 @ 60 Hz, 25 MHz pixel clock). Once per frame, on a one-cycle `frame_tick` from the VGA timing generator at the start of vertical blank, it runs a short multi-cycle update sequence. The sequence moves the paddle from the buttons, steps the ball, and resolves wall, paddle and miss events. Across frames it sequences the game through idle, serve, play, miss and game-over. Its registered `ball_x`, `ball_y` and `paddle_y` feed the pixel renderer.

---
 rtl/pong_pkg.sv | 38 +++
 rtl/pong_ball_step.sv | 71 +++++++
 rtl/pong_game_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and default geometry for the single-paddle Pong controller.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_MISS     = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_e;

  // Per-frame update pipeline: NONE when idle between frames.
  typedef enum logic [1:0] {
    SEQ_NONE   = 2'd0,
    SEQ_PADDLE = 2'd1,
    SEQ_STEP   = 2'd2,
    SEQ_COMMIT = 2'd3
  } seq_e;

  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

  localparam int H_ACTIVE_DEF  = 640;
  localparam int V_ACTIVE_DEF  = 480;
  localparam int BALL_SIZE_DEF = 8;
  localparam int PADDLE_X_DEF  = 16;
  localparam int PADDLE_W_DEF  = 8;
  localparam int PADDLE_H_DEF  = 64;

  function automatic int centre(input int extent, input int size);
    return (extent - size) / 2;
  endfunction

  localparam int CENTRE_BALL_X   = centre(H_ACTIVE_DEF, BALL_SIZE_DEF);
  localparam int CENTRE_BALL_Y   = centre(V_ACTIVE_DEF, BALL_SIZE_DEF);
  localparam int CENTRE_PADDLE_Y = centre(V_ACTIVE_DEF, PADDLE_H_DEF);

endpackage

// File: rtl/pong_ball_step.sv
// Resolves a tentative ball position against walls, paddle and the left edge.
module pong_ball_step
  import pong_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int BALL_SIZE = BALL_SIZE_DEF,
  parameter int PADDLE_X  = PADDLE_X_DEF,
  parameter int PADDLE_W  = PADDLE_W_DEF,
  parameter int PADDLE_H  = PADDLE_H_DEF
) (
  input  logic signed [10:0] nx_i,
  input  logic signed [10:0] ny_i,
  input  logic               dx_i,
  input  logic               dy_i,
  input  logic [9:0]         paddle_y_i,
  output logic [9:0]         x_o,
  output logic [9:0]         y_o,
  output logic               dx_o,
  output logic               dy_o,
  output logic               hit_o,
  output logic               miss_o
);

  localparam logic signed [10:0] S_H    = 11'(H_ACTIVE);
  localparam logic signed [10:0] S_V    = 11'(V_ACTIVE);
  localparam logic signed [10:0] S_BALL = 11'(BALL_SIZE);
  localparam logic signed [10:0] S_PX   = 11'(PADDLE_X);
  localparam logic signed [10:0] S_PW   = 11'(PADDLE_W);
  localparam logic signed [10:0] S_PH   = 11'(PADDLE_H);

  logic signed [10:0] pad_s;
  logic               paddle_overlap;

  assign pad_s = signed'({1'b0, paddle_y_i});
  // Paddle test uses the tentative y, not the wall-resolved y.
  assign paddle_overlap = (dx_i == DIR_NEG) &&
                          (nx_i <= S_PX + S_PW) && (nx_i + S_BALL > S_PX) &&
                          (ny_i + S_BALL > pad_s) && (ny_i < pad_s + S_PH);

  always_comb begin
    y_o  = ny_i[9:0];
    dy_o = dy_i;
    if (ny_i < 11'sd0) begin
      y_o  = '0;
      dy_o = DIR_POS;
    end else if (ny_i + S_BALL > S_V) begin
      y_o  = 10'(V_ACTIVE - BALL_SIZE);
      dy_o = DIR_NEG;
    end
  end

  always_comb begin
    x_o    = nx_i[9:0];
    dx_o   = dx_i;
    hit_o  = 1'b0;
    miss_o = 1'b0;
    if (nx_i + S_BALL > S_H) begin
      x_o  = 10'(H_ACTIVE - BALL_SIZE);
      dx_o = DIR_NEG;
    end else if (paddle_overlap) begin
      x_o   = 10'(PADDLE_X + PADDLE_W);
      dx_o  = DIR_POS;
      hit_o = 1'b1;
    end else if ((dx_i == DIR_NEG) && (nx_i <= 11'sd0)) begin
      x_o    = '0;
      miss_o = 1'b1;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-rate Pong controller: game FSM plus a three-stage per-frame update.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int BALL_SIZE    = BALL_SIZE_DEF,
  parameter int PADDLE_X     = PADDLE_X_DEF,
  parameter int PADDLE_W     = PADDLE_W_DEF,
  parameter int PADDLE_H     = PADDLE_H_DEF,
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SPEED   = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int LIVES        = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle_y,
  output logic [6:0] score,
  output logic [1:0] lives,
  output logic [2:0] state,
  output logic       busy
);

  localparam logic [9:0] BALL_X0    = 10'(centre(H_ACTIVE, BALL_SIZE));
  localparam logic [9:0] BALL_Y0    = 10'(centre(V_ACTIVE, BALL_SIZE));
  localparam logic [9:0] PADDLE_Y0  = 10'(centre(V_ACTIVE, PADDLE_H));
  localparam logic [9:0] PAD_MAX    = 10'(V_ACTIVE - PADDLE_H);
  localparam logic [9:0] P_SPEED    = 10'(PADDLE_SPEED);
  localparam logic signed [10:0] S_SPD = 11'(BALL_SPEED);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [6:0] SCORE_MAX  = 7'd99;
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  state_e state_q, state_d;
  seq_e   seq_q, seq_d;

  logic up_q, down_q, start_s_q, start_d_q;
  logic [9:0] ball_x_q, ball_y_q, paddle_q, pad_new_q, pad_next;
  logic [6:0] score_q;
  logic [1:0] lives_q;
  logic       dx_q, dy_q, serve_dy_q;
  logic [7:0] serve_cnt_q;
  logic signed [10:0] nx_q, ny_q, bx_s, by_s, nx, ny;

  logic       start_rise, commit, serve_done;
  logic [9:0] res_x, res_y;
  logic       res_dx, res_dy, res_hit, res_miss;

  assign start_rise = start_s_q & ~start_d_q;
  assign commit     = (seq_q == SEQ_COMMIT);
  assign serve_done = (serve_cnt_q == SERVE_LAST);

  always_comb begin
    pad_next = paddle_q;
    if (up_q && !down_q) begin
      pad_next = (paddle_q < P_SPEED) ? '0 : paddle_q - P_SPEED;
    end else if (down_q && !up_q) begin
      pad_next = ({1'b0, paddle_q} + {1'b0, P_SPEED} > {1'b0, PAD_MAX}) ?
                 PAD_MAX : paddle_q + P_SPEED;
    end
  end

  assign bx_s = signed'({1'b0, ball_x_q});
  assign by_s = signed'({1'b0, ball_y_q});
  assign nx   = (dx_q == DIR_POS) ? bx_s + S_SPD : bx_s - S_SPD;
  assign ny   = (dy_q == DIR_POS) ? by_s + S_SPD : by_s - S_SPD;

  pong_ball_step #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BALL_SIZE(BALL_SIZE),
    .PADDLE_X (PADDLE_X),
    .PADDLE_W (PADDLE_W),
    .PADDLE_H (PADDLE_H)
  ) u_step (
    .nx_i      (nx_q),
    .ny_i      (ny_q),
    .dx_i      (dx_q),
    .dy_i      (dy_q),
    .paddle_y_i(pad_new_q),
    .x_o       (res_x),
    .y_o       (res_y),
    .dx_o      (res_dx),
    .dy_o      (res_dy),
    .hit_o     (res_hit),
    .miss_o    (res_miss)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      seq_q   <= SEQ_NONE;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
    end
  end

  // Ticks are only accepted between frames, so a tick while busy is dropped.
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    unique case (seq_q)
      SEQ_NONE:   if (frame_tick && (state_q == ST_SERVE || state_q == ST_PLAY))
                    seq_d = SEQ_PADDLE;
      SEQ_PADDLE: seq_d = SEQ_STEP;
      SEQ_STEP:   seq_d = SEQ_COMMIT;
      SEQ_COMMIT: seq_d = SEQ_NONE;
      default:    seq_d = SEQ_NONE;
    endcase
    unique case (state_q)
      ST_IDLE, ST_GAMEOVER: if (start_rise) state_d = ST_SERVE;
      ST_SERVE: if (commit && serve_done) state_d = ST_PLAY;
      ST_PLAY:  if (commit && res_miss) state_d = ST_MISS;
      ST_MISS:  state_d = (lives_q <= 2'd1) ? ST_GAMEOVER : ST_SERVE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      start_s_q   <= 1'b0;
      start_d_q   <= 1'b0;
      ball_x_q    <= BALL_X0;
      ball_y_q    <= BALL_Y0;
      paddle_q    <= PADDLE_Y0;
      pad_new_q   <= PADDLE_Y0;
      nx_q        <= '0;
      ny_q        <= '0;
      score_q     <= '0;
      lives_q     <= LIVES_INIT;
      dx_q        <= DIR_POS;
      dy_q        <= DIR_POS;
      serve_dy_q  <= DIR_POS;
      serve_cnt_q <= '0;
    end else begin
      up_q      <= btn_up;
      down_q    <= btn_down;
      start_s_q <= btn_start;
      start_d_q <= start_s_q;
      if (seq_q == SEQ_PADDLE) pad_new_q <= pad_next;
      if (seq_q == SEQ_STEP) begin
        nx_q <= nx;
        ny_q <= ny;
      end
      if (commit) begin
        paddle_q <= pad_new_q;
        if (state_q == ST_PLAY) begin
          ball_x_q <= res_x;
          ball_y_q <= res_y;
          dx_q     <= res_dx;
          dy_q     <= res_dy;
          if (res_hit && score_q < SCORE_MAX) score_q <= score_q + 7'd1;
        end else if (state_q == ST_SERVE) begin
          // Launch alternates vertical direction from one serve to the next.
          if (serve_done) begin
            serve_cnt_q <= '0;
            dx_q        <= DIR_POS;
            dy_q        <= serve_dy_q;
            serve_dy_q  <= ~serve_dy_q;
          end else begin
            serve_cnt_q <= serve_cnt_q + 8'd1;
          end
        end
      end
      if ((state_q == ST_IDLE || state_q == ST_GAMEOVER) && start_rise) begin
        score_q     <= '0;
        lives_q     <= LIVES_INIT;
        ball_x_q    <= BALL_X0;
        ball_y_q    <= BALL_Y0;
        serve_cnt_q <= '0;
      end
      if (state_q == ST_MISS) begin
        lives_q <= lives_q - 2'd1;
        if (lives_q > 2'd1) begin
          ball_x_q    <= BALL_X0;
          ball_y_q    <= BALL_Y0;
          serve_cnt_q <= '0;
        end
      end
    end
  end

  assign ball_x   = ball_x_q;
  assign ball_y   = ball_y_q;
  assign paddle_y = paddle_q;
  assign score    = score_q;
  assign lives    = lives_q;
  assign state    = state_q;
  assign busy     = (seq_q != SEQ_NONE);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench: full-size game (a) plus a shrunken field (b) for fast score saturation.
module tb_pong_game_ctrl;

  localparam int IDLE = 0, SERVE = 1, PLAY = 2, MISS = 3, GAMEOVER = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic ft_a = 0, up_a = 0, dn_a = 0, st_a = 0;
  logic [9:0] bx_a, by_a, py_a;
  logic [6:0] sc_a;
  logic [1:0] lv_a;
  logic [2:0] fsm_a;
  logic busy_a;

  logic ft_b = 0, st_b = 0, zero_b = 0;
  logic [9:0] bx_b, by_b, py_b;
  logic [6:0] sc_b;
  logic [1:0] lv_b;
  logic [2:0] fsm_b;
  logic busy_b;

  int n_vec = 0;
  int n_err = 0;

  pong_game_ctrl dut_a (
    .clk(clk), .rst(rst), .frame_tick(ft_a), .btn_up(up_a), .btn_down(dn_a),
    .btn_start(st_a), .ball_x(bx_a), .ball_y(by_a), .paddle_y(py_a),
    .score(sc_a), .lives(lv_a), .state(fsm_a), .busy(busy_a)
  );

  pong_game_ctrl #(
    .H_ACTIVE(64), .V_ACTIVE(64), .BALL_SIZE(8), .PADDLE_X(16), .PADDLE_W(8),
    .PADDLE_H(64), .PADDLE_SPEED(4), .BALL_SPEED(2), .SERVE_FRAMES(2), .LIVES(3)
  ) dut_b (
    .clk(clk), .rst(rst), .frame_tick(ft_b), .btn_up(zero_b), .btn_down(zero_b),
    .btn_start(st_b), .ball_x(bx_b), .ball_y(by_b), .paddle_y(py_b),
    .score(sc_b), .lives(lv_b), .state(fsm_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle T+4, where the committed frame is visible.
  task automatic tick_a(input int n);
    for (int i = 0; i < n; i++) begin
      ft_a = 1'b1;
      step();
      ft_a = 1'b0;
      step(); step(); step();
    end
  endtask

  task automatic tick_b(input int n);
    for (int i = 0; i < n; i++) begin
      ft_b = 1'b1;
      step();
      ft_b = 1'b0;
      step(); step(); step();
    end
  endtask

  task automatic chk_ball_a(input string tag, input int x, input int y);
    chk({tag, ".x"}, 32'(bx_a), 32'(x));
    chk({tag, ".y"}, 32'(by_a), 32'(y));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset, 3 cycles.
    rst = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    step();
    chk_ball_a("rst_ball", 316, 236);
    chk("rst_paddle", 32'(py_a), 208);
    chk("rst_score", 32'(sc_a), 0);
    chk("rst_lives", 32'(lv_a), 3);
    chk("rst_state", 32'(fsm_a), IDLE);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_b_ball_x", 32'(bx_b), 28);
    chk("rst_b_state", 32'(fsm_b), IDLE);

    // Tick in IDLE does nothing.
    ft_a = 1'b1; step(); ft_a = 1'b0;
    chk("idle_tick_busy", 32'(busy_a), 0);

    // Start edge: state follows two edges later.
    st_a = 1'b1; step();
    chk("start_lat1", 32'(fsm_a), IDLE);
    step();
    chk("start_lat2", 32'(fsm_a), SERVE);
    st_a = 1'b0;

    // Serve tick 1 with up, watching busy and the all-at-once commit.
    up_a = 1'b1;
    ft_a = 1'b1; step(); ft_a = 1'b0;
    chk("busy_t1", 32'(busy_a), 1);
    step(); step();
    chk("busy_t3", 32'(busy_a), 1);
    chk("no_partial_paddle", 32'(py_a), 208);
    step();
    chk("busy_t4", 32'(busy_a), 0);
    chk("serve_up1", 32'(py_a), 204);
    chk_ball_a("serve_hold", 316, 236);
    dn_a = 1'b1; tick_a(1);
    chk("both_btn", 32'(py_a), 204);
    up_a = 1'b0; tick_a(1);
    chk("down1", 32'(py_a), 208);
    up_a = 1'b1; dn_a = 1'b0; tick_a(56);
    chk("up_clamp", 32'(py_a), 0);
    chk("serve_59", 32'(fsm_a), SERVE);
    tick_a(1);
    chk("serve_60", 32'(fsm_a), PLAY);
    chk_ball_a("launch_hold", 316, 236);
    up_a = 1'b0;

    // Life 1: launch dx=+ dy=+.
    tick_a(1);
    chk_ball_a("play_t1", 318, 238);
    dn_a = 1'b1; tick_a(52); dn_a = 1'b0;
    chk("pad_back", 32'(py_a), 208);
    tick_a(66);
    chk_ball_a("bottom_wall_t119", 554, 472);
    tick_a(40);
    chk_ball_a("right_wall_t159", 632, 392);
    tick_a(304);
    chk_ball_a("paddle_hit_t463", 24, 214);
    chk("hit_score", 32'(sc_a), 1);
    up_a = 1'b1; tick_a(52); up_a = 1'b0;
    chk("pad_away", 32'(py_a), 0);
    tick_a(568);
    chk_ball_a("pre_miss1", 2, 440);
    chk("pre_miss1_state", 32'(fsm_a), PLAY);
    tick_a(1);
    chk("miss1_state", 32'(fsm_a), MISS);
    chk_ball_a("miss1_ball", 0, 438);
    chk("miss1_lives", 32'(lv_a), 3);
    step();
    chk("miss1_serve", 32'(fsm_a), SERVE);
    chk("miss1_lives_dec", 32'(lv_a), 2);
    chk_ball_a("miss1_recentre", 316, 236);

    // Life 2: launch dy=-.
    tick_a(60);
    chk("life2_play", 32'(fsm_a), PLAY);
    tick_a(474);
    chk_ball_a("life2_pre", 2, 236);
    tick_a(1);
    chk("miss2_state", 32'(fsm_a), MISS);
    chk_ball_a("miss2_ball", 0, 234);
    step();
    chk("miss2_lives", 32'(lv_a), 1);

    // Life 3: launch dy=+ again.
    tick_a(60);
    tick_a(475);
    chk("miss3_state", 32'(fsm_a), MISS);
    chk_ball_a("miss3_ball", 0, 238);
    step();
    chk("gameover_state", 32'(fsm_a), GAMEOVER);
    chk("gameover_lives", 32'(lv_a), 0);
    chk("gameover_score", 32'(sc_a), 1);
    tick_a(2);
    chk_ball_a("gameover_freeze", 0, 238);
    chk("gameover_busy", 32'(busy_a), 0);

    // Restart from GAMEOVER.
    st_a = 1'b1; step();
    chk("restart_lat1", 32'(fsm_a), GAMEOVER);
    step();
    chk("restart_state", 32'(fsm_a), SERVE);
    chk("restart_lives", 32'(lv_a), 3);
    chk("restart_score", 32'(sc_a), 0);
    chk_ball_a("restart_ball", 316, 236);
    st_a = 1'b0; step();
    st_a = 1'b1; step(); step(); step();
    chk("start_ignored_serve", 32'(fsm_a), SERVE);
    st_a = 1'b0;

    // Fourth launch has dy=-; second tick at T+2 must be dropped.
    tick_a(60);
    chk("restart_play", 32'(fsm_a), PLAY);
    ft_a = 1'b1; step();
    ft_a = 1'b0; step();
    ft_a = 1'b1; step();
    ft_a = 1'b0; step();
    chk_ball_a("dbl_tick_t4", 318, 234);
    step(); step(); step();
    chk_ball_a("dbl_tick_t7", 318, 234);
    chk("dbl_tick_busy", 32'(busy_a), 0);

    // Reset at T+2 discards the in-flight frame.
    ft_a = 1'b1; step();
    ft_a = 1'b0; step();
    rst = 1'b1; step();
    rst = 1'b0;
    chk("midrst_state", 32'(fsm_a), IDLE);
    chk("midrst_busy", 32'(busy_a), 0);
    chk_ball_a("midrst_ball", 316, 236);
    chk("midrst_paddle", 32'(py_a), 208);
    step(); step(); step();
    chk_ball_a("midrst_no_commit", 316, 236);
    chk("midrst_busy_late", 32'(busy_a), 0);

    // Small field: paddle spans the whole height, every pass is a hit.
    st_b = 1'b1; step(); step();
    chk("b_serve", 32'(fsm_b), SERVE);
    st_b = 1'b0;
    tick_b(2);
    chk("b_play", 32'(fsm_b), PLAY);
    chk("b_ball_x0", 32'(bx_b), 28);
    tick_b(31);
    chk("b_hit1_x", 32'(bx_b), 24);
    chk("b_hit1_score", 32'(sc_b), 1);
    tick_b(3264 - 31);
    chk("b_score98", 32'(sc_b), 98);
    tick_b(1);
    chk("b_score99", 32'(sc_b), 99);
    tick_b(33);
    chk("b_hit100_x", 32'(bx_b), 24);
    chk("b_score_sat", 32'(sc_b), 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
